// File: rtl/cordic_iter.sv
// Folded polar CORDIC engine: STEPS micro-rotations per clock,
// rotating or vectoring per transaction, ready/valid on both sides.
module cordic_iter #(
    parameter int WIDTH      = 16,
    parameter int ITERATIONS = WIDTH + 2,
    parameter int GUARD_BITS = ITERATIONS - 1,
    parameter int STEPS      = 1,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_mode,
    input  logic [TAG_WIDTH-1:0] in_tag,
    input  logic [WIDTH-1:0]     x0,
    input  logic [WIDTH-1:0]     y0,
    input  logic [WIDTH-1:0]     z0,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic [WIDTH:0]       x,
    output logic [WIDTH:0]       y,
    output logic [WIDTH-1:0]     z
);

    localparam int XW = WIDTH + GUARD_BITS + 1;
    localparam int ZW = WIDTH + GUARD_BITS;
    localparam int CW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
    localparam logic [CW-1:0] LAST = CW'(ITERATIONS - STEPS);
    localparam logic [CW-1:0] STEP_INC = CW'(STEPS);
    localparam logic [WIDTH-1:0] QUARTER = WIDTH'(1) << (WIDTH - 2);
    localparam logic [XW-1:0] HALF_X = XW'(1) << (GUARD_BITS - 1);
    localparam logic [ZW-1:0] HALF_Z = ZW'(1) << (GUARD_BITS - 1);
    localparam real PI = 3.14159265358979323846;

    if ((ITERATIONS % STEPS) != 0) begin : g_bad_steps
        $error("cordic_iter: STEPS must divide ITERATIONS");
    end

    function automatic real atan_series(real t);
        real sum, term, t2;
        sum  = 0.0;
        term = t;
        t2   = t * t;
        for (int k = 0; k < 40; k++) begin
            if (k % 2 == 0) sum = sum + term / $itor(2 * k + 1);
            else            sum = sum - term / $itor(2 * k + 1);
            term = term * t2;
        end
        return sum;
    endfunction

    // Angle unit: pi maps to 2**(ZW-1) at internal precision
    function automatic logic [ZW-1:0] atan_fix(int i);
        real t, scale, a;
        t     = 1.0;
        scale = 1.0;
        for (int j = 0; j < i; j++) t = t / 2.0;
        for (int j = 0; j < ZW - 1; j++) scale = scale * 2.0;
        a = (i == 0) ? PI / 4.0 : atan_series(t);
        return ZW'(longint'(scale / PI * a));
    endfunction

    logic [ZW-1:0] atan_tab [ITERATIONS];

    for (genvar g = 0; g < ITERATIONS; g++) begin : g_atan
        localparam logic [ZW-1:0] ATAN_G = atan_fix(g);
        assign atan_tab[g] = ATAN_G;
    end

    typedef enum logic [1:0] {IDLE, ITER, ROUND, DONE} state_t;

    state_t               state, state_n;
    logic                 load;
    logic                 mode;
    logic [TAG_WIDTH-1:0] tag;
    logic [CW-1:0]        cnt, idx;
    logic signed [XW-1:0] xr, yr, px, py, sx, sy, dx, dy, rx, ry;
    logic signed [ZW-1:0] zr, pz, sz, rz;
    logic [WIDTH:0]       xe, ye, xm, ym;
    logic [WIDTH-1:0]     zq;
    logic                 pos_turn, neg_turn;
    logic                 unused_lsbs;

    assign pos_turn = in_mode ? (x0[WIDTH-1] & ~y0[WIDTH-1])
                              : (z0[WIDTH-1:WIDTH-2] == 2'b10);
    assign neg_turn = in_mode ? (x0[WIDTH-1] & y0[WIDTH-1])
                              : (z0[WIDTH-1:WIDTH-2] == 2'b01);

    // Extend before negating so the most negative operand survives
    always_comb begin
        xe = {x0[WIDTH-1], x0};
        ye = {y0[WIDTH-1], y0};
        xm = xe;
        ym = ye;
        zq = z0;
        unique case (1'b1)
            pos_turn: begin xm = ye;  ym = -xe; zq = z0 + QUARTER; end
            neg_turn: begin xm = -ye; ym = xe;  zq = z0 - QUARTER; end
            default: ;
        endcase
        px = {xm, {GUARD_BITS{1'b0}}};
        py = {ym, {GUARD_BITS{1'b0}}};
        pz = {zq, {GUARD_BITS{1'b0}}};
    end

    always_comb begin
        sx  = xr;
        sy  = yr;
        sz  = zr;
        idx = cnt;
        dx  = '0;
        dy  = '0;
        for (int s = 0; s < STEPS; s++) begin
            idx = cnt + CW'(s);
            dx  = sy >>> idx;
            dy  = sx >>> idx;
            if (mode ? !sy[XW-1] : sz[ZW-1]) begin
                sx = sx + dx;
                sy = sy - dy;
                sz = sz + atan_tab[idx];
            end else begin
                sx = sx - dx;
                sy = sy + dy;
                sz = sz - atan_tab[idx];
            end
        end
    end

    assign rx = xr + HALF_X;
    assign ry = yr + HALF_X;
    assign rz = zr + HALF_Z;
    assign unused_lsbs = ^{rx[GUARD_BITS-1:0], ry[GUARD_BITS-1:0],
                           rz[GUARD_BITS-1:0]};

    always_comb begin
        state_n  = state;
        in_ready = 1'b0;
        load     = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    state_n = ITER;
                end
            end
            ITER: if (cnt == LAST) state_n = ROUND;
            ROUND: state_n = DONE;
            DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        load    = 1'b1;
                        state_n = ITER;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode      <= 1'b0;
            tag       <= '0;
            xr        <= '0;
            yr        <= '0;
            zr        <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_tag   <= '0;
            x         <= '0;
            y         <= '0;
            z         <= '0;
        end else begin
            if (load) begin
                mode <= in_mode;
                tag  <= in_tag;
                xr   <= px;
                yr   <= py;
                zr   <= pz;
                cnt  <= '0;
            end else if (state == ITER) begin
                xr  <= sx;
                yr  <= sy;
                zr  <= sz;
                cnt <= cnt + STEP_INC;
            end
            if (state == ROUND) begin
                x         <= rx[XW-1:GUARD_BITS];
                y         <= ry[XW-1:GUARD_BITS];
                z         <= rz[ZW-1:GUARD_BITS];
                out_tag   <= tag;
                out_valid <= 1'b1;
            end else if (state == DONE && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
